// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
//   Shared definitions for the Y86-64 execute-stage ALU.
//   - WORD_W : architectural word width (64 bits)
//   - alu_op_e : 2-bit ALU opcodes, identical to ifun[1:0] of OPq
// ---------------------------------------------------------------------------
package y86_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned OP_W   = 2;

    // Opcode encoding matches the low two bits of the OPq function code
    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    // True when the opcode routes through the adder
    function automatic logic uses_adder(input alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage : y86_pkg

// File: rtl/y86_alu_add_sub64.sv
// ---------------------------------------------------------------------------
// add_sub64
//   Gate-level ripple-carry adder/subtractor.
//   sub=0 : sum = a + b
//   sub=1 : sum = a + ~b + 1  (a - b)
// Ports
//   a    in  WIDTH  operand A
//   b    in  WIDTH  operand B
//   sub  in  1      invert B and force carry-in to 1
//   sum  out WIDTH  result modulo 2^WIDTH (combinational)
//   ovf  out 1      signed overflow of the operation (combinational)
// ---------------------------------------------------------------------------
module add_sub64
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    // Effective B operand after conditional inversion
    logic [WIDTH-1:0] w_b_eff;
    // Ripple carry chain; w_carry[0] is carry-in, w_carry[WIDTH] is carry-out
    logic [WIDTH:0]   w_carry;

    assign w_b_eff    = b ^ {WIDTH{sub}};
    assign w_carry[0] = sub;

    // One full adder per bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic w_p;
        logic w_g;
        assign w_p            = a[i] ^ w_b_eff[i];
        assign w_g            = a[i] & w_b_eff[i];
        assign sum[i]         = w_p ^ w_carry[i];
        assign w_carry[i+1]   = w_g | (w_p & w_carry[i]);
    end

    // Signed overflow: carry into the MSB differs from carry out of the MSB.
    // Equivalent to (a[msb]==b_eff[msb]) && (sum[msb]!=a[msb]), which covers both
    // the ADD and SUB formulas since b_eff is ~b for subtraction.
    assign ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

endmodule : add_sub64

// File: rtl/y86_alu.sv
// ---------------------------------------------------------------------------
// y86_alu
//   64-bit integer ALU for the Y86-64 execute stage: ADD/SUB/AND/XOR with
//   signed-overflow flag. Result and flag are registered (1-cycle latency),
//   a new operation is accepted every cycle.
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high (out=0, flag=0)
//   operation  in   2      00=ADD 01=SUB 10=AND 11=XOR
//   a          in   WIDTH  operand A (two's complement)
//   b          in   WIDTH  operand B (two's complement)
//   out        out  WIDTH  registered result
//   flag       out  1      registered signed-overflow indicator
// ---------------------------------------------------------------------------
module y86_alu
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             flag
);

    alu_op_e          w_op;
    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_res_c;
    logic             w_flag_c;
    logic [WIDTH-1:0] r_out;
    logic             r_flag;

    assign w_op  = alu_op_e'(operation);
    assign w_sub = (w_op == ALU_SUB);

    // Shared adder/subtractor for ADD and SUB
    add_sub64 #(
        .WIDTH (WIDTH)
    ) u_add_sub (
        .a   (a),
        .b   (b),
        .sub (w_sub),
        .sum (w_sum),
        .ovf (w_ovf)
    );

    // Bitwise gate arrays
    assign w_and = a & b;
    assign w_xor = a ^ b;

    // 4:1 result select; overflow only meaningful for arithmetic ops
    always_comb begin
        w_res_c  = '0;
        w_flag_c = 1'b0;
        unique case (w_op)
            ALU_ADD, ALU_SUB: w_res_c = w_sum;
            ALU_AND:          w_res_c = w_and;
            ALU_XOR:          w_res_c = w_xor;
            default:          w_res_c = '0;
        endcase
        if (uses_adder(w_op)) begin
            w_flag_c = w_ovf;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_flag <= 1'b0;
        end else begin
            r_out  <= w_res_c;
            r_flag <= w_flag_c;
        end
    end

    assign out  = r_out;
    assign flag = r_flag;

endmodule : y86_alu

// File: tb/tb_y86_alu.sv
// ---------------------------------------------------------------------------
// tb_y86_alu
//   Directed and random self-checking bench for y86_alu.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_y86_alu;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst;
    logic [1:0]   operation;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         flag;

    int checks;
    int errors;

    y86_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .a         (a),
        .b         (b),
        .out       (out),
        .flag      (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present inputs on the falling edge, away from the capturing edge
    task automatic drive(input logic [1:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        operation = op;
        a         = va;
        b         = vb;
    endtask

    // Advance past the next capturing edge
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Power-on reset value
        #1;
        checks++;
        if (out !== 64'd0 || flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_init out=%h flag=%b exp out=0 flag=0", out, flag);
        end
        @(negedge clk);
        rst = 1'b0;
        // Load a nonzero overflowing result
        drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        settle();
        checks++;
        if (out !== 64'h8000_0000_0000_0000 || flag !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload out=%h flag=%b exp out=8000000000000000 flag=1", out, flag);
        end
        // Assert reset mid-cycle, check without any clock edge
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 64'd0 || flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_async out=%h flag=%b exp out=0 flag=0", out, flag);
        end
        // Held through an edge while asserted
        settle();
        checks++;
        if (out !== 64'd0 || flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold out=%h flag=%b exp out=0 flag=0", out, flag);
        end
        // First edge after release captures normally
        drive(2'b00, 64'd3, 64'd4);
        rst = 1'b0;
        settle();
        checks++;
        if (out !== 64'd7 || flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_release out=%h flag=%b exp out=7 flag=0", out, flag);
        end
    endtask

    task automatic test_add();
        drive(2'b00, 64'd5, 64'd7);
        settle();
        checks++;
        if (out !== 64'd12 || flag !== 1'b0) begin
            errors++;
            $display("FAIL add_5_7 out=%h flag=%b exp out=c flag=0", out, flag);
        end
        drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        settle();
        checks++;
        if (out !== 64'h8000_0000_0000_0000 || flag !== 1'b1) begin
            errors++;
            $display("FAIL add_max_1 out=%h flag=%b exp out=8000000000000000 flag=1", out, flag);
        end
        drive(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        settle();
        checks++;
        if (out !== 64'd0 || flag !== 1'b0) begin
            errors++;
            $display("FAIL add_m1_1 out=%h flag=%b exp out=0 flag=0", out, flag);
        end
        drive(2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        settle();
        checks++;
        if (out !== 64'd0 || flag !== 1'b1) begin
            errors++;
            $display("FAIL add_min_min out=%h flag=%b exp out=0 flag=1", out, flag);
        end
    endtask

    task automatic test_sub();
        drive(2'b01, 64'h100, 64'd8);
        settle();
        checks++;
        if (out !== 64'hF8 || flag !== 1'b0) begin
            errors++;
            $display("FAIL sub_push out=%h flag=%b exp out=f8 flag=0", out, flag);
        end
        drive(2'b01, 64'h8000_0000_0000_0000, 64'd1);
        settle();
        checks++;
        if (out !== 64'h7FFF_FFFF_FFFF_FFFF || flag !== 1'b1) begin
            errors++;
            $display("FAIL sub_min_1 out=%h flag=%b exp out=7fffffffffffffff flag=1", out, flag);
        end
        drive(2'b01, 64'd0, 64'h8000_0000_0000_0000);
        settle();
        checks++;
        if (out !== 64'h8000_0000_0000_0000 || flag !== 1'b1) begin
            errors++;
            $display("FAIL sub_0_min out=%h flag=%b exp out=8000000000000000 flag=1", out, flag);
        end
        // Operand order: 3 - 10 = -7
        drive(2'b01, 64'd3, 64'd10);
        settle();
        checks++;
        if (out !== 64'hFFFF_FFFF_FFFF_FFF9 || flag !== 1'b0) begin
            errors++;
            $display("FAIL sub_order out=%h flag=%b exp out=fffffffffffffff9 flag=0", out, flag);
        end
    endtask

    task automatic test_logic();
        drive(2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        settle();
        checks++;
        if (out !== 64'hF000_F000_F000_F000 || flag !== 1'b0) begin
            errors++;
            $display("FAIL and out=%h flag=%b exp out=f000f000f000f000 flag=0", out, flag);
        end
        drive(2'b11, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        settle();
        checks++;
        if (out !== 64'h0FF0_0FF0_0FF0_0FF0 || flag !== 1'b0) begin
            errors++;
            $display("FAIL xor out=%h flag=%b exp out=0ff00ff00ff00ff0 flag=0", out, flag);
        end
        // Inputs that would overflow an add must not raise the flag for logic ops
        drive(2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        settle();
        checks++;
        if (out !== 64'h7FFF_FFFF_FFFF_FFFF || flag !== 1'b0) begin
            errors++;
            $display("FAIL and_noflag out=%h flag=%b exp out=7fffffffffffffff flag=0", out, flag);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   ops  [4];
        logic [W-1:0] va   [4];
        logic [W-1:0] vb   [4];
        logic [W-1:0] eo   [4];
        logic         ef   [4];
        ops[0] = 2'b00; va[0] = 64'd100;  vb[0] = 64'd23;  eo[0] = 64'd123; ef[0] = 1'b0;
        ops[1] = 2'b01; va[1] = 64'd100;  vb[1] = 64'd23;  eo[1] = 64'd77;  ef[1] = 1'b0;
        ops[2] = 2'b10; va[2] = 64'hFF;   vb[2] = 64'h0F;  eo[2] = 64'h0F;  ef[2] = 1'b0;
        ops[3] = 2'b11; va[3] = 64'hFF;   vb[3] = 64'h0F;  eo[3] = 64'hF0;  ef[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], va[i], vb[i]);
            settle();
            checks++;
            if (out !== eo[i] || flag !== ef[i]) begin
                errors++;
                $display("FAIL b2b_%0d out=%h flag=%b exp out=%h flag=%b", i, out, flag, eo[i], ef[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] eo;
        logic         ef;
        for (int n = 0; n < 10000; n++) begin
            op = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n % 8 == 0) ra[62:0] = '1;
            if (n % 8 == 1) rb[62:0] = '0;
            ef = 1'b0;
            case (op)
                2'b00: begin
                    eo = ra + rb;
                    ef = (ra[63] == rb[63]) && (eo[63] != ra[63]);
                end
                2'b01: begin
                    eo = ra - rb;
                    ef = (ra[63] != rb[63]) && (eo[63] != ra[63]);
                end
                2'b10: eo = ra & rb;
                default: eo = ra ^ rb;
            endcase
            drive(op, ra, rb);
            settle();
            checks++;
            if (out !== eo || flag !== ef) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h out=%h flag=%b exp out=%h flag=%b",
                         n, op, ra, rb, out, flag, eo, ef);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        operation = 2'b00;
        a         = '0;
        b         = '0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_y86_alu
